// File: rtl/peripheral_system_timer_driver_pkg.sv
// Shared definitions for the interval-timer Avalon-MM driver: register map,
// control-word bit positions, client opcodes and the sequencer state encoding.
package peripheral_system_timer_driver_pkg;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
  localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
  localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

  localparam int CTRL_STOP  = 3;
  localparam int CTRL_START = 2;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_ITO   = 0;

  localparam logic [1:0] OP_CONFIG = 2'd0;
  localparam logic [1:0] OP_STOP   = 2'd1;
  localparam logic [1:0] OP_SNAP   = 2'd2;
  localparam logic [1:0] OP_RSVD   = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_PL,
    ST_WR_PH,
    ST_GAP,
    ST_WR_CTRL,
    ST_WR_STOP,
    ST_WR_SNAP,
    ST_RD_SL,
    ST_RD_SH,
    ST_CAP,
    ST_ACK,
    ST_DONE
  } state_e;

  function automatic logic [15:0] ctrl_word(input logic stop, input logic start,
                                            input logic cont, input logic ito);
    logic [15:0] w;
    w             = '0;
    w[CTRL_STOP]  = stop;
    w[CTRL_START] = start;
    w[CTRL_CONT]  = cont;
    w[CTRL_ITO]   = ito;
    return w;
  endfunction

endpackage

// File: rtl/peripheral_system_timer_driver.sv
// Avalon-MM initiator sequencing configure/stop/snapshot commands to the
// 16-bit interval timer and servicing its IRQ autonomously.
module peripheral_system_timer_driver #(
  parameter int CNT_W   = 16,
  parameter int CNT_SAT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [31:0]      cmd_period,
  input  logic             cmd_cont,
  input  logic             cmd_ien,
  output logic             rsp_valid,
  output logic [31:0]      rsp_data,
  output logic [2:0]       tmr_address,
  output logic             tmr_chipselect,
  output logic             tmr_write_n,
  output logic [15:0]      tmr_writedata,
  input  logic [15:0]      tmr_readdata,
  input  logic             tmr_irq,
  output logic [CNT_W-1:0] timeout_count,
  output logic             timeout_pulse
);
  import peripheral_system_timer_driver_pkg::*;

  state_e      state;
  state_e      state_next;
  logic        cmd_accept;
  logic        mode_cont;
  logic        mode_ien;
  logic [15:0] period_hi_q;
  logic [15:0] snap_lo_q;

  logic        bus_cs;
  logic        bus_wn;
  logic [2:0]  bus_addr;
  logic [15:0] bus_wdata;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    if ((CNT_SAT != 0) && (&v))
      return v;
    return v + CNT_W'(1);
  endfunction

  // A pending IRQ blocks new commands so service always wins the IDLE slot.
  assign cmd_ready  = reset_n && (state == ST_IDLE) && !tmr_irq;
  assign cmd_accept = cmd_valid && cmd_ready;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (tmr_irq) begin
          state_next = ST_ACK;
        end else if (cmd_valid) begin
          case (cmd_op)
            OP_CONFIG: state_next = ST_WR_PL;
            OP_STOP:   state_next = ST_WR_STOP;
            OP_SNAP:   state_next = ST_WR_SNAP;
            default:   state_next = ST_DONE;
          endcase
        end
      end
      ST_WR_PL:   state_next = ST_WR_PH;
      ST_WR_PH:   state_next = ST_GAP;
      ST_GAP:     state_next = ST_WR_CTRL;
      ST_WR_CTRL: state_next = ST_DONE;
      ST_WR_STOP: state_next = ST_DONE;
      ST_WR_SNAP: state_next = ST_RD_SL;
      ST_RD_SL:   state_next = ST_RD_SH;
      ST_RD_SH:   state_next = ST_CAP;
      ST_CAP:     state_next = ST_DONE;
      ST_ACK:     state_next = ST_IDLE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Bus signals are decoded from the next state and registered, so each bus
  // cycle lines up exactly with the state that owns it.
  always_comb begin
    bus_cs    = 1'b0;
    bus_wn    = 1'b1;
    bus_addr  = ADDR_STATUS;
    bus_wdata = '0;
    case (state_next)
      ST_WR_PL: begin
        bus_cs    = 1'b1;
        bus_wn    = 1'b0;
        bus_addr  = ADDR_PERIOD_L;
        bus_wdata = cmd_period[15:0];
      end
      ST_WR_PH: begin
        bus_cs    = 1'b1;
        bus_wn    = 1'b0;
        bus_addr  = ADDR_PERIOD_H;
        bus_wdata = period_hi_q;
      end
      ST_WR_CTRL: begin
        bus_cs    = 1'b1;
        bus_wn    = 1'b0;
        bus_addr  = ADDR_CONTROL;
        bus_wdata = ctrl_word(1'b0, 1'b1, mode_cont, mode_ien);
      end
      ST_WR_STOP: begin
        bus_cs    = 1'b1;
        bus_wn    = 1'b0;
        bus_addr  = ADDR_CONTROL;
        bus_wdata = ctrl_word(1'b1, 1'b0, mode_cont, mode_ien);
      end
      ST_WR_SNAP: begin
        bus_cs    = 1'b1;
        bus_wn    = 1'b0;
        bus_addr  = ADDR_SNAP_L;
      end
      ST_RD_SL: begin
        bus_cs    = 1'b1;
        bus_addr  = ADDR_SNAP_L;
      end
      ST_RD_SH: begin
        bus_cs    = 1'b1;
        bus_addr  = ADDR_SNAP_H;
      end
      ST_ACK: begin
        bus_cs    = 1'b1;
        bus_wn    = 1'b0;
        bus_addr  = ADDR_STATUS;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_address    <= '0;
      tmr_writedata  <= '0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      mode_cont      <= 1'b0;
      mode_ien       <= 1'b0;
      timeout_count  <= '0;
      timeout_pulse  <= 1'b0;
    end else begin
      state          <= state_next;
      tmr_chipselect <= bus_cs;
      tmr_write_n    <= bus_wn;
      tmr_address    <= bus_addr;
      tmr_writedata  <= bus_wdata;
      rsp_valid      <= (state_next == ST_DONE);
      // Registered readdata of the high half arrives while in CAP.
      rsp_data       <= (state == ST_CAP) ? {tmr_readdata, snap_lo_q} : '0;
      if (cmd_accept && (cmd_op == OP_CONFIG)) begin
        mode_cont <= cmd_cont;
        mode_ien  <= cmd_ien;
      end
      timeout_pulse  <= (state == ST_ACK);
      if (state == ST_ACK)
        timeout_count <= cnt_inc(timeout_count);
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_accept)
      period_hi_q <= cmd_period[31:16];
    if (state == ST_RD_SH)
      snap_lo_q <= tmr_readdata;
  end

endmodule

// File: tb/tb_peripheral_system_timer_driver.sv
// Randomized self-checking bench: per-command expected bus-cycle tables, a
// small interval-timer slave, and an IRQ counter model for three counter configs.
module tb_peripheral_system_timer_driver;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_period;
  logic        cmd_cont;
  logic        cmd_ien;
  logic [15:0] tmr_readdata = '0;
  logic        tmr_irq = 1'b0;

  logic        cmd_ready, rsp_valid, tmr_chipselect, tmr_write_n, timeout_pulse;
  logic [31:0] rsp_data;
  logic [2:0]  tmr_address;
  logic [15:0] tmr_writedata, timeout_count;

  logic        s_cmd_ready, s_rsp_valid, s_cs, s_wn, s_pulse;
  logic [31:0] s_rsp_data;
  logic [2:0]  s_addr;
  logic [15:0] s_wdata;
  logic [1:0]  s_count;

  logic        w_cmd_ready, w_rsp_valid, w_cs, w_wn, w_pulse;
  logic [31:0] w_rsp_data;
  logic [2:0]  w_addr;
  logic [15:0] w_wdata;
  logic [1:0]  w_count;

  peripheral_system_timer_driver dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_period(cmd_period), .cmd_cont(cmd_cont), .cmd_ien(cmd_ien),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .tmr_address(tmr_address),
    .tmr_chipselect(tmr_chipselect), .tmr_write_n(tmr_write_n),
    .tmr_writedata(tmr_writedata), .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq),
    .timeout_count(timeout_count), .timeout_pulse(timeout_pulse)
  );

  peripheral_system_timer_driver #(.CNT_W(2), .CNT_SAT(1)) dut_sat (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_op(cmd_op), .cmd_period(cmd_period), .cmd_cont(cmd_cont), .cmd_ien(cmd_ien),
    .rsp_valid(s_rsp_valid), .rsp_data(s_rsp_data), .tmr_address(s_addr),
    .tmr_chipselect(s_cs), .tmr_write_n(s_wn), .tmr_writedata(s_wdata),
    .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq),
    .timeout_count(s_count), .timeout_pulse(s_pulse)
  );

  peripheral_system_timer_driver #(.CNT_W(2), .CNT_SAT(0)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(w_cmd_ready),
    .cmd_op(cmd_op), .cmd_period(cmd_period), .cmd_cont(cmd_cont), .cmd_ien(cmd_ien),
    .rsp_valid(w_rsp_valid), .rsp_data(w_rsp_data), .tmr_address(w_addr),
    .tmr_chipselect(w_cs), .tmr_write_n(w_wn), .tmr_writedata(w_wdata),
    .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq),
    .timeout_count(w_count), .timeout_pulse(w_pulse)
  );

  // Reference state
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_irq    = 0;
  bit          m_cont   = 0;
  bit          m_ien    = 0;
  logic [31:0] snap_src = '0;
  logic        irq_raise = 1'b0;
  logic [15:0] sregs [0:7];

  // Interval-timer slave: registered reads, snapshot latch, irq cleared by status write
  always @(posedge clk) begin
    if (tmr_chipselect && !tmr_write_n) begin
      if (tmr_address == 3'd4) begin
        sregs[4] <= snap_src[15:0];
        sregs[5] <= snap_src[31:16];
      end else begin
        sregs[tmr_address] <= tmr_writedata;
      end
    end
    if (tmr_chipselect && tmr_write_n)
      tmr_readdata <= sregs[tmr_address];
    if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd0)
      tmr_irq <= 1'b0;
    else if (irq_raise)
      tmr_irq <= 1'b1;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_counts(input string tag);
    check_val({tag, "_cnt"},  timeout_count, 64'(n_irq % 65536));
    check_val({tag, "_sat"},  s_count, 64'((n_irq > 3) ? 3 : n_irq));
    check_val({tag, "_wrap"}, w_count, 64'(n_irq % 4));
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_idle"}, {tmr_chipselect, tmr_write_n}, 2'b01);
  endtask

  task automatic check_wr(input string tag, input logic [2:0] a, input logic [15:0] d);
    check_val({tag, "_wr"}, {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata},
              {1'b1, 1'b0, a, d});
  endtask

  task automatic check_rd(input string tag, input logic [2:0] a);
    check_val({tag, "_rd"}, {tmr_chipselect, tmr_write_n, tmr_address}, {1'b1, 1'b1, a});
  endtask

  function automatic int op_len(input logic [1:0] op);
    case (op)
      2'd0: return 5;
      2'd1: return 2;
      2'd2: return 5;
      default: return 1;
    endcase
  endfunction

  task automatic expect_service(input string tag);
    bit found = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd0) begin
        found = 1;
        break;
      end
    end
    check_val({tag, "_ack_seen"}, 64'(found), 64'd1);
    if (!found) return;
    check_wr({tag, "_ack"}, 3'd0, 16'h0000);
    check_val({tag, "_pulse_pre"}, timeout_pulse, 1'b0);
    @(negedge clk);
    n_irq++;
    check_val({tag, "_pulse"}, timeout_pulse, 1'b1);
    check_counts(tag);
    check_idle({tag, "_post_ack"});
    @(negedge clk);
    check_val({tag, "_pulse_end"}, timeout_pulse, 1'b0);
    check_val({tag, "_ready_after"}, cmd_ready, 1'b1);
    check_counts({tag, "_hold"});
  endtask

  task automatic do_irq(input string tag);
    @(negedge clk);
    irq_raise = 1'b1;
    @(negedge clk);
    irq_raise = 1'b0;
    check_val({tag, "_ready_blk"}, cmd_ready, 1'b0);
    expect_service(tag);
  endtask

  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [31:0] per,
                        input bit cont, input bit ien, input int irq_at);
    bit ok = 0;
    int len = op_len(op);
    logic [31:0] exp_snap = snap_src;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_period = per; cmd_cont = cont; cmd_ien = ien;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    check_val({tag, "_accept"}, 64'(ok), 64'd1);
    if (!ok) begin cmd_valid = 1'b0; return; end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_period = $urandom; cmd_cont = 1'($urandom); cmd_ien = 1'($urandom);
    if (op == 2'd0) begin m_cont = cont; m_ien = ien; end
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      check_val({tag, "_rsp_valid"}, rsp_valid, 64'(k == len));
      check_val({tag, "_busy"}, cmd_ready, 1'b0);
      case (op)
        2'd0: case (k)
          1: check_wr({tag, "_pl"}, 3'd2, per[15:0]);
          2: check_wr({tag, "_ph"}, 3'd3, per[31:16]);
          4: check_wr({tag, "_ctrl"}, 3'd1, {12'h000, 1'b0, 1'b1, cont, ien});
          default: check_idle(tag);
        endcase
        2'd1: if (k == 1) check_wr({tag, "_stop"}, 3'd1, {12'h000, 1'b1, 1'b0, m_cont, m_ien});
              else check_idle(tag);
        2'd2: case (k)
          1: check_wr({tag, "_snapwr"}, 3'd4, 16'h0000);
          2: check_rd({tag, "_rdl"}, 3'd4);
          3: check_rd({tag, "_rdh"}, 3'd5);
          default: check_idle(tag);
        endcase
        default: check_idle(tag);
      endcase
      if (k == len)
        check_val({tag, "_rsp_data"}, rsp_data, (op == 2'd2) ? exp_snap : 32'h0);
      if (irq_at != 0 && k == irq_at - 1) irq_raise = 1'b1;
      if (irq_at != 0 && k == irq_at) irq_raise = 1'b0;
    end
    if (irq_at != 0) begin
      expect_service({tag, "_irq"});
    end else begin
      @(negedge clk);
      check_val({tag, "_rsp_end"}, rsp_valid, 1'b0);
      check_val({tag, "_ready"}, cmd_ready, 1'b1);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_bus"}, {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata},
              {1'b0, 1'b1, 3'd0, 16'h0000});
    check_val({tag, "_ready"}, cmd_ready, 1'b0);
    check_val({tag, "_rsp"}, {rsp_valid, rsp_data}, 33'h0);
    check_val({tag, "_pulse"}, timeout_pulse, 1'b0);
    check_counts(tag);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_period = '0;
    cmd_cont = 1'b0; cmd_ien = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_val("ready_post_reset", cmd_ready, 1'b1);
    check_idle("idle_post_reset");

    do_cmd("cfg", 2'd0, 32'h000186A0, 1'b1, 1'b1, 0);
    snap_src = 32'h00012345;
    do_cmd("snap", 2'd2, 32'h0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) do_irq("irq");
    do_cmd("cfg_irq", 2'd0, $urandom, 1'b0, 1'b1, 2);
    do_cmd("rsvd", 2'd3, $urandom, 1'b1, 1'b1, 0);
    do_cmd("stop", 2'd1, $urandom, 1'b1, 1'b0, 0);
    do_irq("irq5");
    do_irq("irq6");

    // Reset while the period high half is being written
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_period = $urandom; cmd_cont = 1'b1; cmd_ien = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check_wr("rst_pl", 3'd2, cmd_period[15:0]);
    @(negedge clk);
    check_wr("rst_ph", 3'd3, cmd_period[31:16]);
    reset_n = 1'b0;
    n_irq = 0; m_cont = 0; m_ien = 0;
    #1;
    check_reset_vals("mid_reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_val("ready_after_abort", cmd_ready, 1'b1);
    do_cmd("stop_after_rst", 2'd1, $urandom, 1'b1, 1'b1, 0);

    for (int it = 0; it < 40; it++) begin
      int r = $urandom_range(0, 4);
      if (r == 4) begin
        do_irq("rnd_irq");
      end else begin
        logic [1:0] op = 2'(r);
        int len = op_len(op);
        int ia = 0;
        if (len >= 2 && $urandom_range(0, 2) == 0) ia = $urandom_range(2, len);
        snap_src = $urandom;
        do_cmd("rnd", op, $urandom, 1'($urandom), 1'($urandom), ia);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
